spu_issue_stage: RTL and testbench
==================================

// Module: spu_issue_stage
// PURPOSE
//  Dual-issue stage directly upstream of spuMainModule. Accepts a decoded, in-order instruction pair
//  from decode and routes each instruction to the even or odd pipe.
//  Dual-issues when legal, otherwise issues in order one per cycle. Drives the per-pipe opcode,
//  register-address, immediate, unit_id, PC and br_first_isntr inputs of spuMainModule.
//  Flushes on branch_taken.
// PARAMETERS
//  OPC_W     8      internal opcode width (= INTERNAL_OPCODE_SIZE)
//  UID_W     3      unit id width (= UNIT_ID_SIZE)
//  RA_W      7      register address width (= REG_ADDR_WIDTH)
//  NOP_OPC   'h00   even-pipe NOP opcode
//  LNOP_OPC  'h01   odd-pipe LNOP opcode
//  DEC_W     3+UID_W+OPC_W+4*RA_W+18   decoded-bundle width (derived)
// PORTS
//  clk             in   1      clock; all state updates on rising edge
//  reset           in   1      synchronous, active-high
//  in_valid        in   1      decode presents pair {dec_a, dec_b}
//  in_ready        out  1      stage can take a pair this cycle
//  dec_a, dec_b    in   DEC_W  bundle [0:DEC_W-1] = {pipe(1: 0 even, 1 odd), wr_en, is_br, unit_id, opcode, ra, rb, rc, rt, imm18}
//  dec_b_valid     in   1      dec_b present (0 = single instruction in pair)
//  in_pc           in   32     PC of dec_a; PC of dec_b = in_pc+4
//  stall           in   1      hazard hold; no issue, buffer frozen
//  branch_taken    in   1      from odd pipe; flush buffered pair
//  opcode_even/odd out  OPC_W  issued opcodes (NOP_OPC / LNOP_OPC when idle)
//  addr_{ra,rb,rc,rt}_*_even/odd  out  RA_W  operand/dest addresses of issued instrs
//  imm7/imm10_even/odd, imm16_odd, imm18_odd  out  low bits of imm18
//  unit_id         out  UID_W  unit id of even instr if issued, else of odd instr, else 0
//  PC              out  32     PC of oldest instruction issued this cycle
//  br_first_isntr  out  1      1 when dual-issued pair's first instr is a branch
// BEHAVIOUR
//  - Reset: buffer empty. Opcodes NOP_OPC/LNOP_OPC. All addresses, imms, unit_id, PC and br_first_isntr are 0.
//    in_ready=0 while reset is high.
//  - Buffer: two slots A (older), B, each with a valid bit.
//    in_ready = ~reset & ~branch_taken & (buffer empty | buffer drains completely this cycle).
//    Accept on in_valid&in_ready: A<=dec_a, B<=dec_b, valid_B<=dec_b_valid.
//  - Outputs are registered; an instr accepted at edge N appears on the outputs no earlier than after edge N+1.
//  - Dual-issue when all hold:
//    A,B valid; A.pipe!=B.pipe; not (A.wr_en & A.rt!=0 & A.rt in {B.ra,B.rb,B.rc}) (RAW);
//    not (A.wr_en & B.wr_en & A.rt==B.rt) (WAW). Both slots are cleared.
//    br_first_isntr=A.is_br.
//  - Otherwise issue A alone to its pipe, with NOP/LNOP and rt=0 on the other pipe. B moves to A and issues
//    alone or with nothing next cycle; it never pairs with the following fetch pair. br_first_isntr=0.
//  - Slot B valid with A invalid is illegal, never created.
//  - stall=1: outputs become NOP/LNOP with rt=0 and br_first_isntr=0. Buffer holds; in_ready=0.
//  - branch_taken=1: buffer cleared same edge, outputs NOP/LNOP next cycle, any pending B is discarded.
//    Takes priority over stall and acceptance.
//  - Idle pipe output: opcode NOP/LNOP, addr_rt=0, other fields 0.
//  - PC: A's stored PC on every issue; B inherits pc+4 when it shifts to A.
//  - Reset mid-operation: buffer and outputs return to reset values on that edge; in-flight pair lost.
// TESTING
//  1 Pair {even ADD_WORD_IMMEDIATE rt=1, odd LOAD_QUADWORD_D rt=5}, no deps
//    -> both issued the cycle after acceptance; in_ready=1 same cycle.
//  2 Pair {even ra=0 rt=1, even ra=1 rt=2} (same pipe)
//    -> cycle1 even=A, odd=LNOP; cycle2 even=B; PC 0 then 4.
//  3 Pair {odd SHLQBI rt=12, even FLOATING_ADD ra=12}
//    -> RAW forces split issue, A on odd first; also check rt=0 dest does not trigger RAW.
//  4 Pair {odd branch is_br=1, even ADD}
//    -> dual issue with br_first_isntr=1; branch_taken next cycle clears pending pair; outputs NOP/LNOP.
//  5 stall held 3 cycles with full buffer
//    -> outputs NOP/LNOP, in_ready=0, same pair issues intact when released.
//  6 reset asserted while B pending -> next cycle all outputs reset values, in_ready=0.
//    Deassert reset -> in_ready=1.

Source files
------------

// File: rtl/spu_issue_stage.sv
// Dual-issue stage ahead of spuMainModule: buffers one decoded pair and routes each
// instruction to the even or odd pipe, pairing them when no pipe/RAW/WAW conflict exists.
module spu_issue_stage #(
  parameter int unsigned      OPC_W    = 8,
  parameter int unsigned      UID_W    = 3,
  parameter int unsigned      RA_W     = 7,
  parameter logic [OPC_W-1:0] NOP_OPC  = 'h00,
  parameter logic [OPC_W-1:0] LNOP_OPC = 'h01,
  parameter int unsigned      DEC_W    = 3 + UID_W + OPC_W + 4*RA_W + 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DEC_W-1:0]  dec_a,
  input  logic [DEC_W-1:0]  dec_b,
  input  logic              dec_b_valid,
  input  logic [31:0]       in_pc,
  input  logic              stall,
  input  logic              branch_taken,
  output logic [OPC_W-1:0]  opcode_even,
  output logic [OPC_W-1:0]  opcode_odd,
  output logic [RA_W-1:0]   addr_ra_even,
  output logic [RA_W-1:0]   addr_rb_even,
  output logic [RA_W-1:0]   addr_rc_even,
  output logic [RA_W-1:0]   addr_rt_even,
  output logic [RA_W-1:0]   addr_ra_odd,
  output logic [RA_W-1:0]   addr_rb_odd,
  output logic [RA_W-1:0]   addr_rc_odd,
  output logic [RA_W-1:0]   addr_rt_odd,
  output logic [6:0]        imm7_even,
  output logic [9:0]        imm10_even,
  output logic [6:0]        imm7_odd,
  output logic [9:0]        imm10_odd,
  output logic [15:0]       imm16_odd,
  output logic [17:0]       imm18_odd,
  output logic [UID_W-1:0]  unit_id,
  output logic [31:0]       PC,
  output logic              br_first_isntr
);

  localparam int unsigned RT_LSB   = 18;
  localparam int unsigned RC_LSB   = RT_LSB + RA_W;
  localparam int unsigned RB_LSB   = RC_LSB + RA_W;
  localparam int unsigned RA_LSB   = RB_LSB + RA_W;
  localparam int unsigned OPC_LSB  = RA_LSB + RA_W;
  localparam int unsigned UID_LSB  = OPC_LSB + OPC_W;
  localparam int unsigned BR_BIT   = UID_LSB + UID_W;
  localparam int unsigned WR_BIT   = BR_BIT + 1;
  localparam int unsigned PIPE_BIT = WR_BIT + 1;

  // Issue buffer: slot A is the older instruction, pc_q always belongs to A.
  logic [DEC_W-1:0] a_q, a_d, b_q, b_d;
  logic             va_q, va_d, vb_q, vb_d;
  logic [31:0]      pc_q, pc_d;

  logic             a_pipe, a_wr, b_pipe, b_wr;
  logic [RA_W-1:0]  a_rt, b_ra, b_rb, b_rc, b_rt;
  logic             raw, waw, dual, go, drain, accept;

  always_comb begin
    a_pipe   = a_q[PIPE_BIT];
    a_wr     = a_q[WR_BIT];
    a_rt     = a_q[RT_LSB +: RA_W];
    b_pipe   = b_q[PIPE_BIT];
    b_wr     = b_q[WR_BIT];
    b_ra     = b_q[RA_LSB +: RA_W];
    b_rb     = b_q[RB_LSB +: RA_W];
    b_rc     = b_q[RC_LSB +: RA_W];
    b_rt     = b_q[RT_LSB +: RA_W];
    // r0 as destination never creates a true dependency
    raw      = a_wr & (a_rt != '0) & ((a_rt == b_ra) | (a_rt == b_rb) | (a_rt == b_rc));
    waw      = a_wr & b_wr & (a_rt == b_rt);
    dual     = va_q & vb_q & (a_pipe != b_pipe) & ~raw & ~waw;
    go       = va_q & ~stall & ~branch_taken;
    drain    = go & (dual | ~vb_q);
    in_ready = ~reset & ~branch_taken & ~stall & (~va_q | drain);
    accept   = in_valid & in_ready;
  end

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    va_d = va_q;
    vb_d = vb_q;
    pc_d = pc_q;
    if (branch_taken) begin
      va_d = 1'b0;
      vb_d = 1'b0;
    end else if (go) begin
      if (drain) begin
        va_d = 1'b0;
        vb_d = 1'b0;
      end else begin
        // split issue: B becomes the head and is never re-paired with a new fetch pair
        a_d  = b_q;
        va_d = 1'b1;
        vb_d = 1'b0;
        pc_d = pc_q + 32'd4;
      end
    end
    if (accept) begin
      a_d  = dec_a;
      b_d  = dec_b;
      va_d = 1'b1;
      vb_d = dec_b_valid;
      pc_d = in_pc;
    end
  end

  // Pipe routing of whatever issues this cycle.
  logic             ev_a, ev_b, ev_vld, od_a, od_b, od_vld;
  logic [OPC_W-1:0] e_opc, o_opc;
  logic [RA_W-1:0]  e_ra, e_rb, e_rc, e_rt, o_ra, o_rb, o_rc, o_rt;
  logic [9:0]       e_imm;
  logic [17:0]      o_imm;
  logic [UID_W-1:0] e_uid, o_uid;

  always_comb begin
    ev_a   = go & ~a_pipe;
    ev_b   = go & dual & ~b_pipe;
    od_a   = go & a_pipe;
    od_b   = go & dual & b_pipe;
    ev_vld = ev_a | ev_b;
    od_vld = od_a | od_b;
    e_opc  = ev_a ? a_q[OPC_LSB +: OPC_W] : b_q[OPC_LSB +: OPC_W];
    e_ra   = ev_a ? a_q[RA_LSB +: RA_W]   : b_q[RA_LSB +: RA_W];
    e_rb   = ev_a ? a_q[RB_LSB +: RA_W]   : b_q[RB_LSB +: RA_W];
    e_rc   = ev_a ? a_q[RC_LSB +: RA_W]   : b_q[RC_LSB +: RA_W];
    e_rt   = ev_a ? a_q[RT_LSB +: RA_W]   : b_q[RT_LSB +: RA_W];
    e_imm  = ev_a ? a_q[9:0]              : b_q[9:0];
    e_uid  = ev_a ? a_q[UID_LSB +: UID_W] : b_q[UID_LSB +: UID_W];
    o_opc  = od_a ? a_q[OPC_LSB +: OPC_W] : b_q[OPC_LSB +: OPC_W];
    o_ra   = od_a ? a_q[RA_LSB +: RA_W]   : b_q[RA_LSB +: RA_W];
    o_rb   = od_a ? a_q[RB_LSB +: RA_W]   : b_q[RB_LSB +: RA_W];
    o_rc   = od_a ? a_q[RC_LSB +: RA_W]   : b_q[RC_LSB +: RA_W];
    o_rt   = od_a ? a_q[RT_LSB +: RA_W]   : b_q[RT_LSB +: RA_W];
    o_imm  = od_a ? a_q[17:0]             : b_q[17:0];
    o_uid  = od_a ? a_q[UID_LSB +: UID_W] : b_q[UID_LSB +: UID_W];
  end

  logic [OPC_W-1:0] opc_e_q, opc_e_d, opc_o_q, opc_o_d;
  logic [RA_W-1:0]  ra_e_q, ra_e_d, rb_e_q, rb_e_d, rc_e_q, rc_e_d, rt_e_q, rt_e_d;
  logic [RA_W-1:0]  ra_o_q, ra_o_d, rb_o_q, rb_o_d, rc_o_q, rc_o_d, rt_o_q, rt_o_d;
  logic [9:0]       imm_e_q, imm_e_d;
  logic [17:0]      imm_o_q, imm_o_d;
  logic [UID_W-1:0] uid_q, uid_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic             br_first_q, br_first_d;

  always_comb begin
    opc_e_d    = ev_vld ? e_opc : NOP_OPC;
    ra_e_d     = ev_vld ? e_ra  : '0;
    rb_e_d     = ev_vld ? e_rb  : '0;
    rc_e_d     = ev_vld ? e_rc  : '0;
    rt_e_d     = ev_vld ? e_rt  : '0;
    imm_e_d    = ev_vld ? e_imm : '0;
    opc_o_d    = od_vld ? o_opc : LNOP_OPC;
    ra_o_d     = od_vld ? o_ra  : '0;
    rb_o_d     = od_vld ? o_rb  : '0;
    rc_o_d     = od_vld ? o_rc  : '0;
    rt_o_d     = od_vld ? o_rt  : '0;
    imm_o_d    = od_vld ? o_imm : '0;
    uid_d      = ev_vld ? e_uid : (od_vld ? o_uid : '0);
    // PC tracks the oldest issued instruction and holds across idle cycles
    pc_out_d   = go ? pc_q : pc_out_q;
    br_first_d = go & dual & a_q[BR_BIT];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q        <= '0;
      b_q        <= '0;
      va_q       <= 1'b0;
      vb_q       <= 1'b0;
      pc_q       <= '0;
      opc_e_q    <= NOP_OPC;
      opc_o_q    <= LNOP_OPC;
      ra_e_q     <= '0;
      rb_e_q     <= '0;
      rc_e_q     <= '0;
      rt_e_q     <= '0;
      ra_o_q     <= '0;
      rb_o_q     <= '0;
      rc_o_q     <= '0;
      rt_o_q     <= '0;
      imm_e_q    <= '0;
      imm_o_q    <= '0;
      uid_q      <= '0;
      pc_out_q   <= '0;
      br_first_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      va_q       <= va_d;
      vb_q       <= vb_d;
      pc_q       <= pc_d;
      opc_e_q    <= opc_e_d;
      opc_o_q    <= opc_o_d;
      ra_e_q     <= ra_e_d;
      rb_e_q     <= rb_e_d;
      rc_e_q     <= rc_e_d;
      rt_e_q     <= rt_e_d;
      ra_o_q     <= ra_o_d;
      rb_o_q     <= rb_o_d;
      rc_o_q     <= rc_o_d;
      rt_o_q     <= rt_o_d;
      imm_e_q    <= imm_e_d;
      imm_o_q    <= imm_o_d;
      uid_q      <= uid_d;
      pc_out_q   <= pc_out_d;
      br_first_q <= br_first_d;
    end
  end

  assign opcode_even    = opc_e_q;
  assign opcode_odd     = opc_o_q;
  assign addr_ra_even   = ra_e_q;
  assign addr_rb_even   = rb_e_q;
  assign addr_rc_even   = rc_e_q;
  assign addr_rt_even   = rt_e_q;
  assign addr_ra_odd    = ra_o_q;
  assign addr_rb_odd    = rb_o_q;
  assign addr_rc_odd    = rc_o_q;
  assign addr_rt_odd    = rt_o_q;
  assign imm7_even      = imm_e_q[6:0];
  assign imm10_even     = imm_e_q;
  assign imm7_odd       = imm_o_q[6:0];
  assign imm10_odd      = imm_o_q[9:0];
  assign imm16_odd      = imm_o_q[15:0];
  assign imm18_odd      = imm_o_q;
  assign unit_id        = uid_q;
  assign PC             = pc_out_q;
  assign br_first_isntr = br_first_q;

endmodule

// File: tb/tb_spu_issue_stage.sv
// Directed bench for spu_issue_stage: each cycle's stimulus queues the expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_spu_issue_stage;

  typedef struct packed {
    logic       pipe, wr, br;
    logic [2:0] uid;
    logic [7:0] opc;
    logic [6:0] ra, rb, rc, rt;
    logic [17:0] imm;
  } ins_t;

  typedef struct {
    logic [7:0]  oe, oo;
    logic [6:0]  rae, rte, rbe, rao, rto, rco;
    logic [9:0]  ie;
    logic [17:0] io;
    logic [2:0]  uid;
    logic [31:0] pc;
    logic        br, rdy;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, dec_b_valid, stall, branch_taken;
  logic [59:0] dec_a, dec_b;
  logic [31:0] in_pc;
  logic [7:0]  opcode_even, opcode_odd;
  logic [6:0]  addr_ra_even, addr_rb_even, addr_rc_even, addr_rt_even;
  logic [6:0]  addr_ra_odd, addr_rb_odd, addr_rc_odd, addr_rt_odd;
  logic [6:0]  imm7_even, imm7_odd;
  logic [9:0]  imm10_even, imm10_odd;
  logic [15:0] imm16_odd;
  logic [17:0] imm18_odd;
  logic [2:0]  unit_id;
  logic [31:0] PC;
  logic        br_first_isntr;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  spu_issue_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dec_a(dec_a), .dec_b(dec_b), .dec_b_valid(dec_b_valid), .in_pc(in_pc),
    .stall(stall), .branch_taken(branch_taken),
    .opcode_even(opcode_even), .opcode_odd(opcode_odd),
    .addr_ra_even(addr_ra_even), .addr_rb_even(addr_rb_even),
    .addr_rc_even(addr_rc_even), .addr_rt_even(addr_rt_even),
    .addr_ra_odd(addr_ra_odd), .addr_rb_odd(addr_rb_odd),
    .addr_rc_odd(addr_rc_odd), .addr_rt_odd(addr_rt_odd),
    .imm7_even(imm7_even), .imm10_even(imm10_even), .imm7_odd(imm7_odd),
    .imm10_odd(imm10_odd), .imm16_odd(imm16_odd), .imm18_odd(imm18_odd),
    .unit_id(unit_id), .PC(PC), .br_first_isntr(br_first_isntr)
  );

  always #5 clk = ~clk;

  function automatic ins_t mk(input int pipe, input int wr, input int br, input int uid,
                              input int opc, input int ra, input int rb, input int rc,
                              input int rt, input int imm);
    ins_t r;
    r.pipe = 1'(pipe); r.wr = 1'(wr); r.br = 1'(br); r.uid = 3'(uid); r.opc = 8'(opc);
    r.ra = 7'(ra); r.rb = 7'(rb); r.rc = 7'(rc); r.rt = 7'(rt); r.imm = 18'(imm);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ve/vo say which instruction is expected on the even/odd pipe this cycle
  task automatic expect_out(input logic ve, input ins_t e, input logic vo, input ins_t o,
                            input logic [31:0] pc, input logic br, input logic rdy);
    exp_t x;
    x.oe  = ve ? e.opc : 8'h00;
    x.rae = ve ? e.ra  : 7'd0;
    x.rbe = ve ? e.rb  : 7'd0;
    x.rte = ve ? e.rt  : 7'd0;
    x.ie  = ve ? e.imm[9:0] : 10'd0;
    x.oo  = vo ? o.opc : 8'h01;
    x.rao = vo ? o.ra  : 7'd0;
    x.rco = vo ? o.rc  : 7'd0;
    x.rto = vo ? o.rt  : 7'd0;
    x.io  = vo ? o.imm : 18'd0;
    x.uid = ve ? e.uid : (vo ? o.uid : 3'd0);
    x.pc  = pc;
    x.br  = br;
    x.rdy = rdy;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("opcode_even", 32'(opcode_even), 32'(e.oe));
      chk("opcode_odd",  32'(opcode_odd),  32'(e.oo));
      chk("ra_even",     32'(addr_ra_even), 32'(e.rae));
      chk("rb_even",     32'(addr_rb_even), 32'(e.rbe));
      chk("rt_even",     32'(addr_rt_even), 32'(e.rte));
      chk("ra_odd",      32'(addr_ra_odd),  32'(e.rao));
      chk("rc_odd",      32'(addr_rc_odd),  32'(e.rco));
      chk("rt_odd",      32'(addr_rt_odd),  32'(e.rto));
      chk("imm7_even",   32'(imm7_even),  32'(e.ie[6:0]));
      chk("imm10_even",  32'(imm10_even), 32'(e.ie));
      chk("imm7_odd",    32'(imm7_odd),   32'(e.io[6:0]));
      chk("imm10_odd",   32'(imm10_odd),  32'(e.io[9:0]));
      chk("imm16_odd",   32'(imm16_odd),  32'(e.io[15:0]));
      chk("imm18_odd",   32'(imm18_odd),  32'(e.io));
      chk("unit_id",     32'(unit_id),    32'(e.uid));
      chk("PC",          PC,              e.pc);
      chk("br_first",    32'(br_first_isntr), 32'(e.br));
      chk("in_ready",    32'(in_ready),   32'(e.rdy));
    end
  end

  task automatic drive(input logic rst, input logic iv, input ins_t a, input ins_t b,
                       input logic bv, input logic [31:0] pc, input logic st, input logic bt);
    reset = rst; in_valid = iv; dec_a = a; dec_b = b; dec_b_valid = bv;
    in_pc = pc; stall = st; branch_taken = bt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ins_t z, i1a, i1b, i2a, i2b, i3a, i3b, i3c, i3d, i4a, i4b, i5a, i5b, i6a, i6b;
    z   = '0;
    i1a = mk(0,1,0,1,'h10, 3, 0,0, 1,'h002A5);
    i1b = mk(1,1,0,4,'h20, 2, 0,0, 5,'h12345);
    i2a = mk(0,1,0,2,'h11, 0, 0,0, 1,'h5);
    i2b = mk(0,1,0,3,'h12, 1, 0,0, 2,'h7);
    i3a = mk(1,1,0,5,'h30, 4, 0,0,12,'h111);
    i3b = mk(0,1,0,6,'h40,12,13,0,14,'h22);
    i3c = mk(1,1,0,1,'h31, 7, 0,0, 0,'h3);
    i3d = mk(0,1,0,2,'h41, 0, 0,0, 9,'h9);
    i4a = mk(1,0,1,7,'h50,10, 0,0, 0,'h3FFFF);
    i4b = mk(0,1,0,0,'h11,20, 0,0,21,'h1FF);
    i5a = mk(0,1,0,1,'h13, 1, 0,0, 3,'h0);
    i5b = mk(1,1,0,4,'h21, 2, 0,0, 4,'h0);
    i6a = mk(0,1,0,2,'h14, 5, 0,0, 6,'h55);
    i6b = mk(1,1,0,3,'h22, 7, 0,3, 8,'h66);

    drive(1,0,z,z,0,0,0,0);
    tick();
    // reset state
    drive(1,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h0,0,0);     tick();
    // 1: independent even/odd pair dual-issues
    drive(0,1,i1a,i1b,1,32'h100,0,0); expect_out(0,z,0,z,32'h0,0,1);   tick();
    drive(0,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h0,0,1);     tick();
    // 2: same-pipe pair splits, PC 0 then 4
    drive(0,1,i2a,i2b,1,32'h0,0,0); expect_out(1,i1a,1,i1b,32'h100,0,1); tick();
    drive(0,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h100,0,0);   tick();
    // 3: RAW split, odd-first
    drive(0,1,i3a,i3b,1,32'h200,0,0); expect_out(1,i2a,0,z,32'h0,0,1); tick();
    drive(0,0,z,z,0,0,0,0);         expect_out(1,i2b,0,z,32'h4,0,0);   tick();
    // 3b: rt=0 destination does not block pairing
    drive(0,1,i3c,i3d,1,32'h300,0,0); expect_out(0,z,1,i3a,32'h200,0,1); tick();
    // 4: branch-first pair, then a pending pair flushed by branch_taken
    drive(0,1,i4a,i4b,1,32'h400,0,0); expect_out(1,i3b,0,z,32'h204,0,1); tick();
    drive(0,1,i5a,i5b,1,32'h500,0,0); expect_out(1,i3d,1,i3c,32'h300,0,1); tick();
    drive(0,1,i1a,i1b,1,32'h900,0,1); expect_out(1,i4b,1,i4a,32'h400,1,0); tick();
    drive(0,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h400,0,1);   tick();
    // 5: stall three cycles with a full buffer
    drive(0,1,i6a,i6b,1,32'h600,0,0); expect_out(0,z,0,z,32'h400,0,1); tick();
    drive(0,1,i1a,i1b,1,32'h900,1,0); expect_out(0,z,0,z,32'h400,0,0); tick();
    drive(0,1,i1a,i1b,1,32'h900,1,0); expect_out(0,z,0,z,32'h400,0,0); tick();
    drive(0,1,i1a,i1b,1,32'h900,1,0); expect_out(0,z,0,z,32'h400,0,0); tick();
    drive(0,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h400,0,1);   tick();
    // 6: reset while slot B pending
    drive(0,1,i2a,i2b,1,32'h700,0,0); expect_out(1,i6a,1,i6b,32'h600,0,1); tick();
    drive(1,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h600,0,0);   tick();
    drive(1,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h0,0,0);     tick();
    drive(0,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h0,0,1);     tick();
    drive(0,0,z,z,0,0,0,0);         expect_out(0,z,0,z,32'h0,0,1);     tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
